tt_um_uart_mvm: RTL and testbench
=================================

TT_UM_UART_MVM -- requirements
Module: tt_um_uart_mvm

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): R 8 matrix rows; C 8 matrix columns / vector length; W_X 4 vector element width (signed); W_K 4 matrix element width (signed); W_Y_OUT 16 transmitted result width; CLOCKS_PER_PULSE 4 clocks per UART bit; BITS_PER_WORD 8 UART data bits; PACKET_SIZE_TX 13 TX frame length in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with these ports (name, direction, width, meaning):
- clk, in, 1, clock, all logic on rising edge.
- rst_n, in, 1, reset, asynchronous, active-high.
- ena, in, 1, design enabled; ignored.
- ui_in, in, 8, bit 0 = UART RX line (idle high); bits 7:1 unused.
- uo_out, out, 8, bit 0 = UART TX line (idle high); bits 7:1 = 0.
- uio_in, in, 8, unused.
- uio_out, out, 8, constant 0.
- uio_oe, out, 8, constant 0 (all inputs).

Function
REQ-003 RX SHALL pass through a 2-flop synchronizer before use.
REQ-004 RX frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), CLOCKS_PER_PULSE clocks per bit.
- RX idle to start: first low sample.
- Then wait CLOCKS_PER_PULSE/2 clocks to mid start bit.
- Then sample every CLOCKS_PER_PULSE clocks: 8 data bits, then the stop bit.
- Return to idle after the stop sample.
- A stop bit sampled as 0 (framing error) SHALL still accept the byte.
- Back-to-back frames with 1 idle clock between them SHALL be received.
REQ-005 RX SHALL assemble 36 bytes (C*W_X + R*C*W_K = 288 bits) into a frame. Byte n occupies frame bits [8n+7:8n].
REQ-006 Frame decode:
- x[c] = frame[4c+3:4c], c = 0..7.
- k[r][c] = frame[32+32r+4c+3 : 32+32r+4c].
- All elements are two's-complement signed.
REQ-007 Result: y[r] = sum over c of k[r][c]*x[c], using signed arithmetic, at least 11-bit exact (W_X+W_K+clog2(C)), sign-extended to 16 bits.
REQ-008 Output stream: 16 bytes, in order y[0][7:0], y[0][15:8], y[1][7:0], ... y[7][15:8].
REQ-009 TX frame: start bit 0, 8 data bits LSB first, 4 bits of 1 (stop/padding), CLOCKS_PER_PULSE clocks each, 13 bits total. TX SHALL stay high between frames.
REQ-010 Buffering:
- On the 36th byte, the frame SHALL be copied to a holding register and a pending flag SHALL be set.
- RX SHALL then immediately accept the next frame.
REQ-011 When TX is idle and pending=1:
- Compute y, combinationally or sequentially in no more than R+2 clocks.
- Load the 128-bit TX buffer and clear pending.
- Start transmitting. The first start bit SHALL begin no more than R+4 clocks after the 36th stop-bit sample.
REQ-012 A frame completing while TX is busy SHALL wait in the holding register. A further frame completing while pending=1 SHALL overwrite the holding register.
REQ-013 Results SHALL be sent in the order frames complete, with no loss as long as frames are no closer than one full TX burst apart.
REQ-014 Recommended states:
- RX FSM: IDLE, START, DATA, STOP.
- TX FSM: IDLE, LOAD, SEND, with bit counter 0..12 and byte counter 0..15.
- SEND returns to IDLE after byte 15 bit 12.

Reset
REQ-015 While reset is asserted, and immediately on assertion:
- uo_out[0] = 1 and all other outputs = 0.
- RX and TX FSMs are IDLE.
- Byte counters are 0, pending = 0.
- The partially received frame is discarded.
REQ-016 After reset is released, the first low RX sample SHALL start a new frame at byte 0.

Verification
REQ-017 36 bytes 0x00 -> 16 bytes 0x00.
REQ-018 Bytes 0-3 = 0x11 (x=1), bytes 4-35 = 0x11 (k=1) -> y=8, output repeats 0x08,0x00 eight times.
REQ-019 All 36 bytes = 0x88 (x=k=-8) -> y=512, output repeats 0x00,0x02; all bytes = 0x77 for k with x bytes = 0x88 -> y=-448, output repeats 0x40,0xFE.
REQ-020 Reset pulse after 10 RX bytes, then a full frame with x=1, k=1 -> exactly one 16-byte response, all pairs 0x08,0x00.
REQ-021 Ten random frames, byte gaps of 1-20 idle clocks, frame gaps of 1-100 clocks -> ten responses in order, each matching the software matrix-vector product. Every TX frame has 4 trailing high bits.

Source files
------------

// File: rtl/tt_um_uart_mvm.sv
// tt_um_uart_mvm: UART-fed signed matrix-vector multiplier; 36 RX bytes in, 16 TX bytes (y[0..7], 16-bit LE) out.
module tt_um_uart_mvm #(
    parameter int R                = 8,
    parameter int C                = 8,
    parameter int W_X              = 4,
    parameter int W_K              = 4,
    parameter int W_Y_OUT          = 16,
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int PACKET_SIZE_TX   = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int N_BITS = C*W_X + R*C*W_K;
    localparam int N_RX   = N_BITS / BITS_PER_WORD;
    localparam int N_TX   = R*W_Y_OUT / BITS_PER_WORD;
    localparam int N_PAD  = PACKET_SIZE_TX - BITS_PER_WORD - 1;
    localparam int CW     = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int BW     = $clog2(PACKET_SIZE_TX + 1);
    localparam int RBW    = $clog2(N_RX + 1);
    localparam int TBW    = $clog2(N_TX + 1);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] CLK_HALF = CW'(CLOCKS_PER_PULSE/2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_state_t;

    logic unused_ok;
    assign unused_ok = ^{ena, ui_in[7:1], uio_in};
    assign uio_out = '0;
    assign uio_oe  = '0;

    logic rx_meta, rx;
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) {rx, rx_meta} <= 2'b11;
        else       {rx, rx_meta} <= {rx_meta, ui_in[0]};

    rx_state_t               rx_state, rx_next;
    logic [CW-1:0]           rx_clk;
    logic [BW-1:0]           rx_bit;
    logic [RBW-1:0]          rx_byte;
    logic [BITS_PER_WORD-1:0] rx_data;
    logic [N_BITS-1:0]       frame, hold;
    logic                    rx_tick, byte_done, frame_done, pending;

    assign rx_tick    = rx_clk == (rx_state == RX_START ? CLK_HALF : CLK_LAST);
    assign byte_done  = rx_state == RX_STOP && rx_tick;
    assign frame_done = byte_done && rx_byte == RBW'(N_RX - 1);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == BW'(BITS_PER_WORD - 1)) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // The stop sample is not checked: a framing error still delivers the byte.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_state <= RX_IDLE;
            rx_clk   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
            rx_data  <= '0;
            frame    <= '0;
            hold     <= '0;
        end else begin
            rx_state <= rx_next;
            rx_clk   <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_clk + 1'b1;
            rx_bit   <= rx_state != RX_DATA ? '0 : rx_tick ? rx_bit + 1'b1 : rx_bit;
            if (rx_state == RX_DATA && rx_tick) rx_data <= {rx, rx_data[BITS_PER_WORD-1:1]};
            if (byte_done) begin
                frame   <= {rx_data, frame[N_BITS-1:BITS_PER_WORD]};
                rx_byte <= frame_done ? '0 : rx_byte + 1'b1;
            end
            if (frame_done) hold <= {rx_data, frame[N_BITS-1:BITS_PER_WORD]};
        end
    end

    logic [R*W_Y_OUT-1:0]       y_bus;
    logic signed [W_X-1:0]      xx;
    logic signed [W_K-1:0]      kk;
    logic signed [W_Y_OUT-1:0]  p, acc;
    always_comb begin
        y_bus = '0;
        xx    = '0;
        kk    = '0;
        p     = '0;
        acc   = '0;
        for (int r = 0; r < R; r++) begin
            acc = '0;
            for (int c = 0; c < C; c++) begin
                xx  = hold[c*W_X +: W_X];
                kk  = hold[C*W_X + (r*C + c)*W_K +: W_K];
                p   = kk * xx;
                acc = acc + p;
            end
            y_bus[r*W_Y_OUT +: W_Y_OUT] = acc;
        end
    end

    tx_state_t             tx_state, tx_next;
    logic [CW-1:0]         tx_clk;
    logic [BW-1:0]         tx_bit;
    logic [TBW-1:0]        tx_byte;
    logic [R*W_Y_OUT-1:0]  tx_buf;
    logic [PACKET_SIZE_TX-1:0] tx_frame;
    logic                  tx_tick, bit_end, tx_last;

    assign tx_tick  = tx_clk == CLK_LAST;
    assign bit_end  = tx_tick && tx_bit == BW'(PACKET_SIZE_TX - 1);
    assign tx_last  = bit_end && tx_byte == TBW'(N_TX - 1);
    assign tx_frame = {{N_PAD{1'b1}}, tx_buf[BITS_PER_WORD-1:0], 1'b0};
    assign uo_out   = {7'b0, tx_state == TX_SEND ? tx_frame[tx_bit] : 1'b1};

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (pending) tx_next = TX_LOAD;
            TX_LOAD: tx_next = TX_SEND;
            TX_SEND: if (tx_last) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // A frame finishing during LOAD keeps pending set so it is sent next.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tx_state <= TX_IDLE;
            tx_clk   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_buf   <= '0;
            pending  <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_clk   <= (tx_state != TX_SEND || tx_tick) ? '0 : tx_clk + 1'b1;
            tx_bit   <= (tx_state != TX_SEND || bit_end) ? '0 : tx_tick ? tx_bit + 1'b1 : tx_bit;
            tx_byte  <= tx_state != TX_SEND ? '0 : bit_end ? tx_byte + 1'b1 : tx_byte;
            pending  <= frame_done ? 1'b1 : tx_state == TX_LOAD ? 1'b0 : pending;
            if (tx_state == TX_LOAD) tx_buf <= y_bus;
            else if (bit_end)        tx_buf <= tx_buf >> BITS_PER_WORD;
        end
    end
endmodule

// File: tb/tb_tt_um_uart_mvm.sv
// tb_tt_um_uart_mvm: drives UART frames into tt_um_uart_mvm and scoreboards the returned bytes.
module tb_tt_um_uart_mvm;
    localparam int CPP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h01;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    always #5 clk = ~clk;

    tt_um_uart_mvm dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    int         n_tests = 0, n_fail = 0, n_exp = 0, n_got = 0;
    logic [8:0] exp_q[$];
    logic [7:0] frm[36];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nib(input logic [7:0] b, input int hi);
        logic [3:0] n;
        n = hi != 0 ? b[7:4] : b[3:0];
        return n[3] ? int'(n) - 16 : int'(n);
    endfunction

    task automatic push_expected();
        for (int r = 0; r < 8; r++) begin
            int acc;
            logic [15:0] y;
            acc = 0;
            for (int c = 0; c < 8; c++)
                acc += nib(frm[c/2], c%2) * nib(frm[4 + 4*r + c/2], c%2);
            y = acc[15:0];
            exp_q.push_back({1'b0, y[7:0]});
            exp_q.push_back({1'b0, y[15:8]});
            n_exp += 2;
        end
    endtask

    task automatic drive_bit(input logic v);
        ui_in[0] = v;
        repeat (CPP) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b1);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int gmin, input int gmax);
        push_expected();
        for (int i = 0; i < 36; i++) send_byte(frm[i], $urandom_range(gmax, gmin));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (uo_out[0] == 1'b0) begin
                logic [7:0] d;
                logic [3:0] s;
                logic [8:0] e;
                repeat (CPP/2) @(negedge clk);
                check("tx_start", uo_out[0], 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPP) @(negedge clk);
                    d[i] = uo_out[0];
                end
                for (int j = 0; j < 4; j++) begin
                    repeat (CPP) @(negedge clk);
                    s[j] = uo_out[0];
                end
                check("tx_stop", s, 4'hF);
                e = exp_q.size() > 0 ? exp_q.pop_front() : 9'h100;
                n_got++;
                check("tx_byte", {1'b0, d}, e);
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in 95000 cycles");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_uo_out", uo_out, 8'h01);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h00);
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        foreach (frm[i]) frm[i] = 8'h00;
        send_frame(1, 1);
        drain();
        foreach (frm[i]) frm[i] = 8'h11;
        send_frame(1, 3);
        drain();
        foreach (frm[i]) frm[i] = 8'h88;
        send_frame(1, 1);
        drain();
        foreach (frm[i]) frm[i] = i < 4 ? 8'h88 : 8'h77;
        send_frame(1, 2);
        drain();

        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1);
        rst_n = 1'b1;
        #1;
        check("rst_async_tx", uo_out, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_tx", uo_out, 8'h01);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        foreach (frm[i]) frm[i] = 8'h11;
        send_frame(1, 1);
        drain();
        check("idle_after_reset_test", uo_out, 8'h01);

        for (int f = 0; f < 10; f++) begin
            foreach (frm[i]) frm[i] = 8'($urandom);
            send_frame(1, 20);
            repeat ($urandom_range(100, 1)) @(posedge clk);
            #1;
        end
        drain();
        check("byte_count", n_got, n_exp);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
